down_timer: RTL

DOWN_TIMER -- requirements
Module: down_timer

---
 rtl/down_timer.sv | 70 +++++++
 1 files changed

// File: rtl/down_timer.sv
// down_timer: loadable down-counter with pause, auto-reload and expiry count.
// Define DOWN_TIMER_PRESCALE_EN to tick once every PRESCALE clocks instead of every clock.
module down_timer #(
  parameter int DATA_BITS = 32,
  parameter int PRESCALE  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [DATA_BITS-1:0] load_value,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 auto_reload,
  output logic [DATA_BITS-1:0] count_out,
  output logic                 expired,
  output logic                 busy,
  output logic [7:0]           expire_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state, state_d;
  logic [DATA_BITS-1:0] reload_reg;
  logic load_acc, go, tick, expire;
  if (PRESCALE < 2 || PRESCALE > 65535) begin : g_bad_prescale
    $error("PRESCALE out of range");
  end
`ifdef DOWN_TIMER_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);
  logic [PW-1:0] pre;
  assign tick = state == RUN && !stop && pre == PW'(PRESCALE - 1);
  // restarts on RUN entry and after each tick (which covers expiry); frozen outside RUN
  always_ff @(posedge clk)
    if (!rst || go || tick) pre <= '0;
    else if (state == RUN && !stop) pre <= pre + PW'(1);
`else
  assign tick = state == RUN && !stop;
`endif
  always_comb begin
    load_acc = load_valid && load_ready;
    go       = !load_acc && start && !stop && state != RUN && count_out != '0;
    expire   = tick && count_out == DATA_BITS'(1);
  end
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= state_d;
  always_comb
    state_d = load_acc ? IDLE :
              go ? RUN :
              (state == RUN && stop) ? PAUSE :
              (expire && !auto_reload) ? DONE : state;
  always_comb begin
    busy       = state == RUN;
    load_ready = state != RUN;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      count_out  <= '0;
      reload_reg <= '0;
      expired    <= 1'b0;
      expire_cnt <= '0;
    end else begin
      expired <= expire;
      if (expired && expire_cnt != 8'd255) expire_cnt <= expire_cnt + 8'd1;
      if (load_acc) begin
        count_out  <= load_value;
        reload_reg <= load_value;
      end else if (expire) count_out <= auto_reload ? reload_reg : '0;
      else if (tick && count_out != '0) count_out <= count_out - DATA_BITS'(1);
    end
endmodule
